apb_to_obi: RTL
===============

# apb_to_obi

APB-to-OBI bridge. It is an APB completer (subordinate) on one side and an OBI manager on the other. It converts each APB transfer into exactly one OBI request/response transaction. It lets APB-only masters (debug/test access, external config ports) reach OBI-attached memories and peripherals in the zeroHETI fabric, the reverse direction of the existing OBI-to-APB bridge.

## Interface
Parameters:
- ADDR_WIDTH, 32, APB/OBI address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 256, response-timeout limit in cycles; only used with the timeout feature

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  APB write
- paddr_i  in  ADDR_WIDTH  APB address
- pwdata_i  in  DATA_WIDTH  APB write data
- pstrb_i  in  DATA_WIDTH/8  APB write strobes
- pprot_i  in  3  accepted and ignored
- prdata_o  out  DATA_WIDTH  registered read data
- pready_o  out  1  transfer complete
- pslverr_o  out  1  transfer error
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  ADDR_WIDTH  registered address
- obi_we_o  out  1  registered write enable
- obi_be_o  out  DATA_WIDTH/8  registered byte enables
- obi_wdata_o  out  DATA_WIDTH  registered write data
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  DATA_WIDTH  OBI read data
- obi_err_i  in  1  OBI response error

## Operation
- FSM states are IDLE, REQ, RSP, DONE, DRAIN. DRAIN exists only with the timeout feature.
- **IDLE:** when psel_i=1 and penable_i=0 (APB setup phase):
  - capture paddr_i into obi_addr_o, pwrite_i into obi_we_o and pwdata_i into obi_wdata_o;
  - capture obi_be_o = pstrb_i for writes and all-ones for reads;
  - go to REQ.
- **REQ:** obi_req_o=1 while addr/we/be/wdata are held stable. When obi_gnt_i=1, go to RSP; obi_req_o is 0 from the next cycle. Once asserted, req is never retracted before gnt.
- **RSP:** obi_rvalid_i is ignored in every other state. When obi_rvalid_i=1:
  - capture prdata_o = obi_rdata_i on reads; prdata_o is left unchanged on writes;
  - capture pslverr_o = obi_err_i;
  - go to DONE.
- **DONE:** pready_o=1 for exactly one cycle, then go to IDLE. pslverr_o is valid only while pready_o=1 and is cleared to 0 on leaving DONE.
- pready_o is 0 in every state except DONE. The APB master therefore sees wait states until the OBI response has been registered.
- If psel_i drops mid-transaction (an APB protocol violation), the OBI transaction still completes and the bridge returns to IDLE.
- Exactly one outstanding OBI transaction at any time.
- **Reset values:** state=IDLE; pready_o, pslverr_o, obi_req_o and obi_we_o are 0; prdata_o, obi_addr_o, obi_be_o and obi_wdata_o are all zeros.
- Reset asserted mid-transaction forces IDLE immediately and drops obi_req_o asynchronously. The OBI subordinate must share this reset domain.

## Timing
- T0: APB setup cycle (psel=1, penable=0).
- T1: obi_req_o=1. If obi_gnt_i=1 at T1, the bridge is in RSP at T2.
- Earliest rvalid is T2. DONE follows at T3 with pready_o=1, so the minimum APB transfer is 4 cycles (setup plus 3 access).
- Each cycle of gnt delay or rvalid delay adds exactly one APB wait state.
- Back-to-back transfers: the next setup phase is accepted in the cycle after DONE. No dead cycle is added beyond APB's own setup phase.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro APB_TO_OBI_TIMEOUT_EN.
- **Defined:**
  - a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering RSP and increments every RSP cycle without rvalid;
  - when it reaches TIMEOUT_CYCLES, go to DONE with pslverr_o=1 and prdata_o=0;
  - the FSM then goes to DRAIN instead of IDLE;
  - DRAIN waits for the late obi_rvalid_i, discards it, then goes to IDLE;
  - new APB setup phases are not accepted in DRAIN;
  - the REQ state is never timed out.
- **Undefined:** no counter and no DRAIN state; RSP waits indefinitely.

## Test plan
- **Write:** APB write addr 0x100, data 0xDEADBEEF, strb 0xF; gnt at T1, rvalid at T2 → OBI we=1, be=0xF, wdata=0xDEADBEEF; pready_o=1 at T3, pslverr_o=0.
- **Read:** APB read addr 0x204, pstrb=0; OBI returns 0x12345678 → obi_be_o=0xF; prdata_o=0x12345678 with pready_o=1.
- **Delays:** gnt delayed 3 cycles, rvalid delayed 2 cycles → pready_o rises exactly 5 cycles later than the minimum; req/addr stable throughout; req deasserts the cycle after gnt.
- **Error:** rvalid with obi_err_i=1 on a write → pslverr_o=1 only in the pready cycle; the next transfer sees pslverr_o=0.
- **Timeout** (macro on, TIMEOUT_CYCLES=8): no rvalid → pready_o=1 with pslverr_o=1 and prdata_o=0 after 8 RSP cycles. A late rvalid carrying 0xAAAA is discarded, and the following read returns fresh data.
- **Reset:** assert rst_i while in REQ → obi_req_o=0 immediately; all outputs at reset values; after release, a new transfer completes normally.

Source files
------------

// File: rtl/apb_to_obi.sv
// Purpose: APB completer to OBI manager bridge; each APB transfer becomes exactly one OBI req/rsp.
// Latency: setup + 3 access cycles minimum; each gnt or rvalid delay cycle adds one APB wait state.
// Backpressure: pready_o held low until the OBI response is registered; one OBI transaction outstanding.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   APB completer: psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, pprot_i (ignored),
//                  prdata_o, pready_o, pslverr_o
//   OBI manager:   obi_req_o, obi_gnt_i, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
//                  obi_rvalid_i, obi_rdata_i, obi_err_i
// Option: define APB_TO_OBI_TIMEOUT_EN to add a response timeout (TIMEOUT_CYCLES) and a DRAIN
// state that swallows the late response; without it RSP waits indefinitely.

module apb_to_obi #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  input  logic [2:0]              pprot_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
`ifdef APB_TO_OBI_TIMEOUT_EN
    , S_DRAIN
`endif
  } state_e;

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

`ifdef APB_TO_OBI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Compare against LIMIT-1 so the timeout fires after exactly TIMEOUT_CYCLES RSP cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;   // current DONE was produced by a timeout
`endif

  // Protection attributes carry no meaning for the OBI side.
  logic unused_ok;
  assign unused_ok = (^pprot_i) ^ (TIMEOUT_CYCLES == 0);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;
`ifdef APB_TO_OBI_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_d      = to_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Capture on the APB setup phase so the request goes out during the first access cycle.
        if (psel_i && !penable_i) begin
          addr_d  = paddr_i;
          we_d    = pwrite_i;
          wdata_d = pwdata_i;
          be_d    = pwrite_i ? pstrb_i : {BE_WIDTH{1'b1}};
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // Request is held until granted; psel_i dropping here does not abort the transaction.
        if (obi_gnt_i) begin
          req_d   = 1'b0;
          state_d = S_RSP;
`ifdef APB_TO_OBI_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_RSP: begin
        if (obi_rvalid_i) begin
          if (!we_q) begin
            prdata_d = obi_rdata_i;
          end
          pslverr_d = obi_err_i;
          pready_d  = 1'b1;
          state_d   = S_DONE;
        end
`ifdef APB_TO_OBI_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          cnt_d     = cnt_q + CNT_W'(1);
          prdata_d  = '0;
          pslverr_d = 1'b1;
          pready_d  = 1'b1;
          to_d      = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_DONE: begin
        pslverr_d = 1'b0;
        state_d   = S_IDLE;
`ifdef APB_TO_OBI_TIMEOUT_EN
        // After a timeout the response is still owed; a response landing in this very cycle
        // is the late one, so it is consumed here instead of leaving DRAIN waiting forever.
        if (to_q) begin
          to_d    = 1'b0;
          state_d = obi_rvalid_i ? S_IDLE : S_DRAIN;
        end
`endif
      end

`ifdef APB_TO_OBI_TIMEOUT_EN
      S_DRAIN: begin
        // Late response is discarded; APB setup phases are ignored until it arrives.
        if (obi_rvalid_i) begin
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

`ifdef APB_TO_OBI_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
`endif

  assign obi_req_o   = req_q;
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_wdata_o = wdata_q;
  assign prdata_o    = prdata_q;
  assign pready_o    = pready_q;
  assign pslverr_o   = pslverr_q;

endmodule
